// File: rtl/scr1_dmem_copy_engine.sv
// Word-by-word block copy master for the SCR1 dmem port: each word is one read then one write,
// with a single request outstanding at a time.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

package scr1_memif_pkg;
  localparam int unsigned SCR1_VEC_LANES = 4;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef logic [SCR1_VEC_LANES-1:0][31:0] type_vector;
endpackage

module scr1_dmem_copy_engine
  import scr1_memif_pkg::*;
#(
  parameter int unsigned LEN_W            = 16,
  parameter int unsigned SCR1_DMEM_AWIDTH = `SCR1_DMEM_AWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [SCR1_DMEM_AWIDTH-1:0] src_addr,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dst_addr,
  input  logic [LEN_W-1:0]            len,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [LEN_W-1:0]            words_done,
  output logic                        dmem_req,
  input  logic                        dmem_req_ack,
  output type_scr1_mem_cmd_e          dmem_cmd,
  output type_scr1_mem_width_e        dmem_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  output type_vector                  dmem_wdata,
  input  type_vector                  dmem_rdata,
  input  type_scr1_mem_resp_e         dmem_resp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_WR_REQ,
    ST_WR_RESP
  } state_e;

  state_e                        state_q, state_d;
  logic [SCR1_DMEM_AWIDTH-1:0]   src_q, src_d;
  logic [SCR1_DMEM_AWIDTH-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]              len_q, len_d;
  logic [LEN_W-1:0]              words_q, words_d;
  logic [31:0]                   data_q, data_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          rdata_unused;

  // Only lane 0 carries the word; upper lanes are deliberately ignored.
  assign rdata_unused = ^dmem_rdata[SCR1_VEC_LANES-1:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      words_q <= words_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    words_d    = words_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    dmem_req   = 1'b0;
    dmem_cmd   = SCR1_MEM_CMD_RD;
    dmem_addr  = '0;
    dmem_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          words_d = '0;
          err_d   = 1'b0;
          if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        dmem_req  = 1'b1;
        dmem_addr = src_q;
        if (dmem_req_ack) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
          data_d  = dmem_rdata[0];
          state_d = ST_WR_REQ;
        end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        dmem_req      = 1'b1;
        dmem_cmd      = SCR1_MEM_CMD_WR;
        dmem_addr     = dst_q;
        dmem_wdata[0] = data_q;
        if (dmem_req_ack) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
          words_d = words_q + LEN_W'(1);
          src_d   = src_q + SCR1_DMEM_AWIDTH'(4);
          dst_d   = dst_q + SCR1_DMEM_AWIDTH'(4);
          if (words_d == len_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD_REQ;
          end
        end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;
  assign dmem_width = SCR1_MEM_WIDTH_WORD;

endmodule

// File: tb/tb_scr1_dmem_copy_engine.sv
// Bench for scr1_dmem_copy_engine: a TCM model scoreboards every accepted request against
// expected transactions queued by the scenario tasks.
module tb_scr1_dmem_copy_engine;
  import scr1_memif_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [31:0]          src_addr = '0;
  logic [31:0]          dst_addr = '0;
  logic [15:0]          len = '0;
  logic                 busy, done, err;
  logic [15:0]          words_done;
  logic                 dmem_req;
  logic                 dmem_req_ack = 1'b1;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  type_vector           dmem_wdata;
  type_vector           dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   err_wr_idx = -1;
  txn_t exp_q[$];
  txn_t mon_got, mon_want;
  logic [31:0] mem [logic [31:0]];

  scr1_dmem_copy_engine #(.LEN_W(16), .SCR1_DMEM_AWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err), .words_done(words_done),
    .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // TCM model: response one cycle after the accepting edge; also the scoreboard checker.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem_rdata <= '0;
    end else begin
      dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem_rdata <= '0;
      if (dmem_req && dmem_req_ack) begin
        mon_got.wr   = (dmem_cmd == SCR1_MEM_CMD_WR);
        mon_got.addr = dmem_addr;
        mon_got.data = mon_got.wr ? dmem_wdata[0] : 32'h0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req: got wr=%0b addr=%h data=%h, expected no request",
                   mon_got.wr, mon_got.addr, mon_got.data);
        end else begin
          mon_want = exp_q.pop_front();
          if (mon_got !== mon_want) begin
            errors++;
            $display("FAIL bus_txn: got wr=%0b addr=%h data=%h, expected wr=%0b addr=%h data=%h",
                     mon_got.wr, mon_got.addr, mon_got.data, mon_want.wr, mon_want.addr, mon_want.data);
          end
        end
        checks++;
        if (dmem_width !== SCR1_MEM_WIDTH_WORD || dmem_wdata[SCR1_VEC_LANES-1:1] !== '0) begin
          errors++;
          $display("FAIL width_lanes: got width=%0d upper=%h, expected width=%0d upper=0",
                   dmem_width, dmem_wdata[SCR1_VEC_LANES-1:1], SCR1_MEM_WIDTH_WORD);
        end
        if (mon_got.wr) begin
          if (wr_cnt == err_wr_idx) begin
            dmem_resp <= SCR1_MEM_RESP_RDY_ER;
          end else begin
            mem[dmem_addr] = dmem_wdata[0];
            dmem_resp <= SCR1_MEM_RESP_RDY_OK;
          end
          wr_cnt++;
        end else begin
          dmem_resp     <= SCR1_MEM_RESP_RDY_OK;
          dmem_rdata    <= '1;
          dmem_rdata[0] <= mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
        end
      end
    end
  end

  task automatic push_rd(input logic [31:0] a);
    exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic issue(input logic [31:0] s_a, input logic [31:0] d_a, input logic [15:0] n,
                       output int s);
    @(negedge clk);
    src_addr = s_a;
    dst_addr = d_a;
    len      = n;
    start    = 1'b1;
    s        = cyc;
  endtask

  // Fixed-length observation window; all times are relative to the start cycle.
  task automatic observe(input int budget, input int s, output int first_req, output int done_at,
                         output int err_at, output int n_done, output bit busy_seen,
                         output bit busy_at_done, output bit both);
    first_req = -1; done_at = -1; err_at = -1; n_done = 0;
    busy_seen = 1'b0; busy_at_done = 1'b0; both = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (dmem_req && first_req < 0) first_req = cyc - s;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at      = cyc - s;
          busy_at_done = busy;
        end
      end
      if (err && err_at < 0) err_at = cyc - s;
      if (done && err) both = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, dmem_req} !== 4'b0000 || words_done !== 16'h0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b err=%b req=%b words=%0d, expected all 0",
               busy, done, err, dmem_req, words_done);
    end
    checks++;
    if (dmem_cmd !== SCR1_MEM_CMD_RD || dmem_addr !== 32'h0 || dmem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_bus: got cmd=%0d addr=%h wdata=%h, expected cmd=0 addr=0 wdata=0",
               dmem_cmd, dmem_addr, dmem_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_copy();
    int s, fr, da, ea, nd;
    bit bs, bd, bo;
    mem[32'h100] = 32'h11111111; mem[32'h104] = 32'h22222222; mem[32'h108] = 32'h33333333;
    for (int unsigned i = 0; i < 3; i++) begin
      push_rd(32'h100 + 4 * i);
      push_wr(32'h200 + 4 * i, 32'h11111111 * (i + 1));
    end
    issue(32'h100, 32'h200, 16'd3, s);
    observe(24, s, fr, da, ea, nd, bs, bd, bo);
    checks++;
    if (fr !== 1) begin errors++; $display("FAIL copy_first_req: got %0d expected 1", fr); end
    checks++;
    if (da - fr !== 12) begin errors++; $display("FAIL copy_latency: got %0d expected 12", da - fr); end
    checks++;
    if (nd !== 1 || bd !== 1'b0 || ea !== -1 || bo) begin
      errors++;
      $display("FAIL copy_flags: got done_pulses=%0d busy_at_done=%b err_at=%0d both=%b, expected 1 0 -1 0",
               nd, bd, ea, bo);
    end
    checks++;
    if (words_done !== 16'd3) begin errors++; $display("FAIL copy_words: got %0d expected 3", words_done); end
    checks++;
    if (mem[32'h208] !== 32'h33333333 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL copy_mem: got mem208=%h pending=%0d expected 33333333 0", mem[32'h208], exp_q.size());
    end
  endtask

  task automatic test_ack_hold();
    int s, fr, da, ea, nd;
    bit bs, bd, bo;
    for (int unsigned i = 0; i < 3; i++) begin
      push_rd(32'h100 + 4 * i);
      push_wr(32'h240 + 4 * i, 32'h11111111 * (i + 1));
    end
    dmem_req_ack = 1'b0;
    issue(32'h100, 32'h240, 16'd3, s);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_cmd !== SCR1_MEM_CMD_RD) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got req=%b addr=%h cmd=%0d expected req=1 addr=100 cmd=0",
                 i, dmem_req, dmem_addr, dmem_cmd);
      end
    end
    dmem_req_ack = 1'b1;
    observe(20, s, fr, da, ea, nd, bs, bd, bo);
    checks++;
    if (nd !== 1 || words_done !== 16'd3 || exp_q.size() != 0 || mem[32'h248] !== 32'h33333333) begin
      errors++;
      $display("FAIL hold_complete: got done=%0d words=%0d pending=%0d mem248=%h expected 1 3 0 33333333",
               nd, words_done, exp_q.size(), mem[32'h248]);
    end
  endtask

  task automatic test_resp_err();
    int s, fr, da, ea, nd;
    bit bs, bd, bo;
    mem[32'h300] = 32'hAAAA0001; mem[32'h304] = 32'hBBBB0002; mem[32'h308] = 32'hCCCC0003;
    push_rd(32'h300); push_wr(32'h400, 32'hAAAA0001);
    push_rd(32'h304); push_wr(32'h404, 32'hBBBB0002);
    err_wr_idx = wr_cnt + 1;
    issue(32'h300, 32'h400, 16'd3, s);
    observe(20, s, fr, da, ea, nd, bs, bd, bo);
    checks++;
    if (ea !== 9 || err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rderr_flag: got err_at=%0d err=%b busy=%b expected 9 1 0", ea, err, busy);
    end
    checks++;
    if (words_done !== 16'd1 || nd !== 0 || exp_q.size() != 0 || mem.exists(32'h404)) begin
      errors++;
      $display("FAIL rderr_state: got words=%0d done_pulses=%0d pending=%0d wrote404=%b expected 1 0 0 0",
               words_done, nd, exp_q.size(), mem.exists(32'h404));
    end
    err_wr_idx = -1;
    mem[32'h900] = 32'h5A5A5A5A;
    push_rd(32'h900); push_wr(32'hA00, 32'h5A5A5A5A);
    issue(32'h900, 32'hA00, 16'd1, s);
    observe(8, s, fr, da, ea, nd, bs, bd, bo);
    checks++;
    if (err !== 1'b0 || ea !== -1 || nd !== 1 || da !== 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL err_clear: got err=%b err_at=%0d done_pulses=%0d done_at=%0d pending=%0d expected 0 -1 1 5 0",
               err, ea, nd, da, exp_q.size());
    end
  endtask

  task automatic test_misaligned_len0();
    int s, fr, da, ea, nd;
    bit bs, bd, bo;
    issue(32'h102, 32'h200, 16'd2, s);
    observe(6, s, fr, da, ea, nd, bs, bd, bo);
    checks++;
    if (ea !== 1 || fr !== -1 || bs || nd !== 0) begin
      errors++;
      $display("FAIL misaligned: got err_at=%0d first_req=%0d busy_seen=%b done=%0d expected 1 -1 0 0",
               ea, fr, bs, nd);
    end
    issue(32'h100, 32'h200, 16'd0, s);
    observe(6, s, fr, da, ea, nd, bs, bd, bo);
    checks++;
    if (da !== 1 || nd !== 1 || fr !== -1 || ea !== -1 || bs) begin
      errors++;
      $display("FAIL len_zero: got done_at=%0d done=%0d first_req=%0d err_at=%0d busy_seen=%b expected 1 1 -1 -1 0",
               da, nd, fr, ea, bs);
    end
  endtask

  task automatic test_wrap();
    int s, fr, da, ea, nd;
    bit bs, bd, bo;
    mem[32'h800] = 32'hDEAD0000; mem[32'h804] = 32'hBEEF0001;
    push_rd(32'h800); push_wr(32'hFFFFFFFC, 32'hDEAD0000);
    push_rd(32'h804); push_wr(32'h00000000, 32'hBEEF0001);
    issue(32'h800, 32'hFFFFFFFC, 16'd2, s);
    observe(14, s, fr, da, ea, nd, bs, bd, bo);
    checks++;
    if (nd !== 1 || da !== 9 || exp_q.size() != 0 || mem[32'h0] !== 32'hBEEF0001) begin
      errors++;
      $display("FAIL wrap: got done=%0d done_at=%0d pending=%0d mem0=%h expected 1 9 0 beef0001",
               nd, da, exp_q.size(), mem[32'h0]);
    end
  endtask

  task automatic test_busy_start_reset();
    int s, fr, da, ea, nd;
    bit bs, bd, bo;
    mem[32'h500] = 32'h12345678;
    push_rd(32'h500);
    issue(32'h500, 32'h600, 16'd2, s);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    src_addr = 32'h700; dst_addr = 32'h780; len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (dmem_req !== 1'b1 || dmem_cmd !== SCR1_MEM_CMD_WR || dmem_addr !== 32'h600 ||
        dmem_wdata[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_req_phase: got req=%b cmd=%0d addr=%h data=%h expected 1 1 600 12345678",
               dmem_req, dmem_cmd, dmem_addr, dmem_wdata[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0 || dmem_cmd !== SCR1_MEM_CMD_RD || dmem_addr !== 32'h0 ||
        dmem_wdata !== '0 || done !== 1'b0 || err !== 1'b0 || words_done !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got req=%b busy=%b cmd=%0d addr=%h wdata=%h done=%b err=%b words=%0d expected all 0",
               dmem_req, busy, dmem_cmd, dmem_addr, dmem_wdata, done, err, words_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    observe(12, cyc, fr, da, ea, nd, bs, bd, bo);
    checks++;
    if (fr !== -1 || nd !== 0 || bs || ea !== -1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle: got first_req=%0d done=%0d busy_seen=%b err_at=%0d pending=%0d expected -1 0 0 -1 0",
               fr, nd, bs, ea, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_ack_hold();
    test_resp_err();
    test_misaligned_len0();
    test_wrap();
    test_busy_start_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scr1_dmem_copy_engine.md
Name: scr1_dmem_copy_engine

Overview:
- Initiator-side master on the SCR1 core data-memory interface (dmem_req / dmem_req_ack / dmem_cmd / dmem_width / dmem_addr / dmem_wdata / dmem_rdata / dmem_resp).
- Copies a block of 32-bit words from a source address to a destination address, one word at a time, using a read then a write per word.
- Drives the dmem port of the TCM (or the dmem arbiter in front of it) so the RLWE datapath can move polynomial coefficient blocks without core load/store loops.

Parameters:
- LEN_W, 16, width of the word-count field; maximum transfer is 2^LEN_W-1 words.
- SCR1_DMEM_AWIDTH, `SCR1_DMEM_AWIDTH, address width, taken from the arch description.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe, sampled only in IDLE
- src_addr  in  SCR1_DMEM_AWIDTH  source byte address; bits[1:0] must be 0
- dst_addr  in  SCR1_DMEM_AWIDTH  destination byte address; bits[1:0] must be 0
- len  in  LEN_W  number of words to copy
- busy  out  1  high from the accepted start until the done/err cycle
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error flag; cleared by the next accepted start
- words_done  out  LEN_W  count of words fully written in the current or last command
- dmem_req  out  1  request valid
- dmem_req_ack  in  1  request accepted at the rising edge where dmem_req=1 and dmem_req_ack=1
- dmem_cmd  out  type_scr1_mem_cmd_e  SCR1_MEM_CMD_RD or SCR1_MEM_CMD_WR
- dmem_width  out  type_scr1_mem_width_e  always SCR1_MEM_WIDTH_WORD
- dmem_addr  out  SCR1_DMEM_AWIDTH  request address
- dmem_wdata  out  type_vector  lane 0 = write word; other lanes = 0
- dmem_rdata  in  type_vector  only lane 0 is used
- dmem_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER

Behaviour:
- Reset values: dmem_req=0, dmem_cmd=RD, dmem_addr=0, dmem_wdata=0, busy=0, done=0, err=0, words_done=0, FSM=IDLE.
- Reset mid-transfer aborts immediately; no done is produced afterwards.
- States: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP.
- IDLE + start:
  - Latch src_addr, dst_addr, len; clear err and words_done.
  - If src_addr[1:0]!=0 or dst_addr[1:0]!=0: set err; no bus activity; busy stays 0.
  - Else if len==0: done=1 in the next cycle; no bus activity.
  - Else: busy=1, go to RD_REQ.
- start is ignored while busy=1.
- RD_REQ: dmem_req=1, cmd=RD, addr=current src.
  - cmd, addr and wdata stay stable until the acknowledging edge.
  - On that edge, go to RD_RESP; dmem_req is 0 in the following cycle.
- RD_RESP: dmem_req=0; wait while resp==NOTRDY.
  - RDY_OK: capture dmem_rdata[0] into the data register; go to WR_REQ.
  - RDY_ER: set err, clear busy, go to IDLE, no done.
- WR_REQ: dmem_req=1, cmd=WR, addr=current dst, wdata lane0=data register. Acknowledge handling as in RD_REQ; go to WR_RESP.
- WR_RESP: wait while resp==NOTRDY.
  - RDY_OK: words_done+1; src+=4, dst+=4 (modulo 2^AWIDTH, wrap silently).
  - If words_done+1==len: done=1 for one cycle, busy=0 in the same cycle, go to IDLE.
  - Else go to RD_REQ.
  - RDY_ER: same handling as in RD_RESP.
- At most one outstanding request; a new request is never raised while a response is pending.
- Throughput with a TCM (req_ack=1, resp one cycle later): 4 cycles per word. done is asserted 4*len cycles after the first dmem_req cycle.
- err and done are never high in the same cycle.

Test Plan:
- Copy src=0x100, dst=0x200, len=3 with TCM words 0x11111111/0x22222222/0x33333333 -> reads 0x100,0x104,0x108; writes same data to 0x200,0x204,0x208; done at cycle 12; words_done=3.
- req_ack held low 5 cycles on the first read -> dmem_req, addr=0x100 and cmd=RD held stable all 5 cycles; then normal completion.
- resp=RDY_ER on the second write -> err=1, busy=0, words_done=1, no done, no further requests; next start clears err.
- Misaligned src=0x102, or len=0 -> err=1 with no dmem_req (misaligned); done pulse the cycle after start with no dmem_req (len=0).
- start pulsed while busy; rst_n low during WR_REQ -> second start ignored; on reset, dmem_req drops asynchronously and all outputs return to reset values.
- dst=0xFFFFFFFC, len=2 (AWIDTH=32) -> second write goes to 0x00000000.
